cv32e40p_tmr_fault_monitor: RTL and testbench

Sequential fault bookkeeping stage placed directly downstream of the TMR majority voter. Each cycle it consumes the voter's per-replica mismatch flags and classifies every replica as healthy, suspect or permanently faulty. It keeps saturating error counters and raises a one-cycle alarm on every new permanent or uncorrectable fault. Software or the debug unit reads and clears the accumulated status.

---
 rtl/cv32e40p_tmr_fault_monitor_if.sv | 30 +++
 rtl/cv32e40p_tmr_fault_monitor.sv | 125 ++++++++++++
 tb/tb_cv32e40p_tmr_fault_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_tmr_fault_monitor_if.sv
// Voter-to-monitor bundle: per-replica mismatch flags in, fault status out.
interface cv32e40p_tmr_fault_monitor_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 valid_i;
  logic                 err_a_i;
  logic                 err_b_i;
  logic                 err_c_i;
  logic                 clear_i;
  logic [CNT_WIDTH-1:0] err_cnt_a_o;
  logic [CNT_WIDTH-1:0] err_cnt_b_o;
  logic [CNT_WIDTH-1:0] err_cnt_c_o;
  logic [2:0]           suspect_o;
  logic [2:0]           perm_fault_o;
  logic                 uncorrectable_o;
  logic                 degraded_o;
  logic                 alarm_o;

  modport master (
    output valid_i, err_a_i, err_b_i, err_c_i, clear_i,
    input  err_cnt_a_o, err_cnt_b_o, err_cnt_c_o, suspect_o, perm_fault_o,
           uncorrectable_o, degraded_o, alarm_o
  );

  modport slave (
    input  valid_i, err_a_i, err_b_i, err_c_i, clear_i,
    output err_cnt_a_o, err_cnt_b_o, err_cnt_c_o, suspect_o, perm_fault_o,
           uncorrectable_o, degraded_o, alarm_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Per-replica fault classification (OK/SUSPECT/FAULTY) behind the TMR voter,
// with saturating error counters, sticky uncorrectable flag and alarm pulse.
module cv32e40p_tmr_fault_monitor #(
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned PERM_THRESHOLD = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  cv32e40p_tmr_fault_monitor_if.slave bus
);

  localparam int unsigned NREP   = 3;
  localparam int unsigned CONS_W = 4;
  localparam logic [CONS_W-1:0]    PERM_TH = CONS_W'(PERM_THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } state_e;

  state_e               state_q [NREP];
  state_e               state_d [NREP];
  logic [CONS_W-1:0]    cons_q  [NREP];
  logic [CONS_W-1:0]    cons_d  [NREP];
  logic [CNT_WIDTH-1:0] cnt_q   [NREP];
  logic [CNT_WIDTH-1:0] cnt_d   [NREP];
  logic                 unc_q, unc_d;
  logic                 alarm_q, alarm_d;
  logic [NREP-1:0]      flag;
  logic [NREP-1:0]      enter_fault;
  logic [NREP-1:0]      suspect_vec;
  logic [NREP-1:0]      faulty_vec;
  logic                 sample;

  assign flag   = {bus.err_c_i, bus.err_b_i, bus.err_a_i};
  assign sample = bus.valid_i & ~bus.clear_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREP; i++) begin
        state_q[i] <= ST_OK;
        cons_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      unc_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREP; i++) begin
        state_q[i] <= state_d[i];
        cons_q[i]  <= cons_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      unc_q   <= unc_d;
      alarm_q <= alarm_d;
    end
  end

  // Next state for all replicas; clear wins over a same-cycle sample.
  always_comb begin
    unc_d       = unc_q;
    alarm_d     = 1'b0;
    enter_fault = '0;
    for (int i = 0; i < NREP; i++) begin
      state_d[i] = state_q[i];
      cons_d[i]  = cons_q[i];
      cnt_d[i]   = cnt_q[i];
      if (bus.clear_i) begin
        state_d[i] = ST_OK;
        cons_d[i]  = '0;
        cnt_d[i]   = '0;
      end else if (sample && flag[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        case (state_q[i])
          ST_OK: begin
            state_d[i] = ST_SUSPECT;
            cons_d[i]  = CONS_W'(1);
          end
          ST_SUSPECT: begin
            cons_d[i] = cons_q[i] + CONS_W'(1);
            if (cons_q[i] + CONS_W'(1) == PERM_TH) begin
              state_d[i]     = ST_FAULTY;
              enter_fault[i] = 1'b1;
            end
          end
          ST_FAULTY: ;
          default: begin
            state_d[i] = ST_OK;
            cons_d[i]  = '0;
          end
        endcase
      end else if (sample && state_q[i] != ST_FAULTY) begin
        state_d[i] = ST_OK;
        cons_d[i]  = '0;
      end
    end
    if (bus.clear_i) begin
      unc_d = 1'b0;
    end else if (sample && (&flag)) begin
      unc_d = 1'b1;
    end
    alarm_d = ~bus.clear_i & ((|enter_fault) | (unc_d & ~unc_q));
  end

  // Status decode straight from the state flops.
  always_comb begin
    suspect_vec = '0;
    faulty_vec  = '0;
    for (int i = 0; i < NREP; i++) begin
      suspect_vec[i] = (state_q[i] == ST_SUSPECT);
      faulty_vec[i]  = (state_q[i] == ST_FAULTY);
    end
  end

  assign bus.err_cnt_a_o     = cnt_q[0];
  assign bus.err_cnt_b_o     = cnt_q[1];
  assign bus.err_cnt_c_o     = cnt_q[2];
  assign bus.suspect_o       = suspect_vec;
  assign bus.perm_fault_o    = faulty_vec;
  assign bus.uncorrectable_o = unc_q;
  assign bus.degraded_o      = |faulty_vec;
  assign bus.alarm_o         = alarm_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Self-checking bench: vector table through a scoreboard queue, plus
// hand sequences for counter saturation and asynchronous reset.
module tb_cv32e40p_tmr_fault_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_tmr_fault_monitor_if #(.CNT_WIDTH(8)) bus ();
  cv32e40p_tmr_fault_monitor_if #(.CNT_WIDTH(2)) bus2 ();

  assign bus2.valid_i = bus.valid_i;
  assign bus2.err_a_i = bus.err_a_i;
  assign bus2.err_b_i = bus.err_b_i;
  assign bus2.err_c_i = bus.err_c_i;
  assign bus2.clear_i = bus.clear_i;

  cv32e40p_tmr_fault_monitor #(.CNT_WIDTH(8), .PERM_THRESHOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  cv32e40p_tmr_fault_monitor #(.CNT_WIDTH(2), .PERM_THRESHOLD(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic       valid;
    logic [2:0] err;   // {c, b, a}
    logic       clear;
    logic [7:0] ca, cb, cc;
    logic [2:0] sus, perm;
    logic       unc, deg, alarm;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tag_q[$];
  int   n_cmp  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int valid, int err, int clear, int ca, int cb, int cc,
                              int sus, int perm, int unc, int deg, int alarm);
    vec_t v;
    v.valid = 1'(valid); v.err = 3'(err); v.clear = 1'(clear);
    v.ca = 8'(ca); v.cb = 8'(cb); v.cc = 8'(cc);
    v.sus = 3'(sus); v.perm = 3'(perm);
    v.unc = 1'(unc); v.deg = 1'(deg); v.alarm = 1'(alarm);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic compare_pop();
    vec_t e;
    int   idx;
    e   = exp_q.pop_front();
    idx = tag_q.pop_front();
    chk("err_cnt_a", idx, 32'(bus.err_cnt_a_o), 32'(e.ca));
    chk("err_cnt_b", idx, 32'(bus.err_cnt_b_o), 32'(e.cb));
    chk("err_cnt_c", idx, 32'(bus.err_cnt_c_o), 32'(e.cc));
    chk("suspect", idx, 32'(bus.suspect_o), 32'(e.sus));
    chk("perm_fault", idx, 32'(bus.perm_fault_o), 32'(e.perm));
    chk("uncorrectable", idx, 32'(bus.uncorrectable_o), 32'(e.unc));
    chk("degraded", idx, 32'(bus.degraded_o), 32'(e.deg));
    chk("alarm", idx, 32'(bus.alarm_o), 32'(e.alarm));
  endtask

  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    bus.valid_i = v.valid;
    bus.err_a_i = v.err[0];
    bus.err_b_i = v.err[1];
    bus.err_c_i = v.err[2];
    bus.clear_i = v.clear;
    exp_q.push_back(v);
    tag_q.push_back(idx);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic chk_all_zero(string name, int idx);
    chk({name, "_cnt_a"}, idx, 32'(bus.err_cnt_a_o), 32'd0);
    chk({name, "_cnt_b"}, idx, 32'(bus.err_cnt_b_o), 32'd0);
    chk({name, "_cnt_c"}, idx, 32'(bus.err_cnt_c_o), 32'd0);
    chk({name, "_suspect"}, idx, 32'(bus.suspect_o), 32'd0);
    chk({name, "_perm"}, idx, 32'(bus.perm_fault_o), 32'd0);
    chk({name, "_unc"}, idx, 32'(bus.uncorrectable_o), 32'd0);
    chk({name, "_degraded"}, idx, 32'(bus.degraded_o), 32'd0);
    chk({name, "_alarm"}, idx, 32'(bus.alarm_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.err_a_i = 1'b0;
    bus.err_b_i = 1'b0;
    bus.err_c_i = 1'b0;
    bus.clear_i = 1'b0;

    // Clean samples: nothing moves, no alarm.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    // A: three errors then a clean sample returns to OK.
    vecs.push_back(mk(1, 3'b001, 0, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 0, 2, 0, 0, 3'b001, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 0, 3, 0, 0, 3'b001, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 0, 3, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    // B: four errors with invalid gaps (gap flags ignored) -> FAULTY.
    vecs.push_back(mk(1, 3'b010, 0, 3, 1, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 3, 1, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 0, 3, 2, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 3, 2, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 0, 3, 3, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 3, 3, 0, 3'b010, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 0, 3, 4, 0, 3'b000, 3'b010, 0, 1, 1));
    vecs.push_back(mk(1, 3'b010, 0, 3, 5, 0, 3'b000, 3'b010, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 3, 5, 0, 3'b000, 3'b010, 0, 1, 0));
    // All three flags: uncorrectable, then A and C fault together (one pulse).
    vecs.push_back(mk(1, 3'b111, 0, 4, 6, 1, 3'b101, 3'b010, 1, 1, 1));
    vecs.push_back(mk(1, 3'b111, 0, 5, 7, 2, 3'b101, 3'b010, 1, 1, 0));
    vecs.push_back(mk(1, 3'b101, 0, 6, 7, 3, 3'b101, 3'b010, 1, 1, 0));
    vecs.push_back(mk(1, 3'b101, 0, 7, 7, 4, 3'b000, 3'b111, 1, 1, 1));
    // Clear with err_c while C is FAULTY.
    vecs.push_back(mk(1, 3'b100, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    // All three from clean state, uncorrectable stays sticky.
    vecs.push_back(mk(1, 3'b111, 0, 1, 1, 1, 3'b111, 3'b000, 1, 0, 1));
    vecs.push_back(mk(1, 3'b111, 0, 2, 2, 2, 3'b111, 3'b000, 1, 0, 0));
    vecs.push_back(mk(1, 3'b000, 0, 2, 2, 2, 3'b000, 3'b000, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    // Clear beats the sample that would complete C's threshold.
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 1, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 2, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 3, 3'b100, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b100, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset", 0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i + 1);

    // Saturation: narrow-counter instance must stick at 3.
    apply(mk(0, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0), 100);
    for (int k = 1; k <= 5; k++) begin
      vec_t v;
      int   sat;
      if (k <= 3) v = mk(1, 3'b111, 0, k, k, k, 3'b111, 3'b000, 1, 0, (k == 1) ? 1 : 0);
      else        v = mk(1, 3'b111, 0, k, k, k, 3'b000, 3'b111, 1, 1, (k == 4) ? 1 : 0);
      apply(v, 100 + k);
      sat = (k < 3) ? k : 3;
      chk("sat_cnt_a", 100 + k, 32'(bus2.err_cnt_a_o), 32'(sat));
      chk("sat_cnt_b", 100 + k, 32'(bus2.err_cnt_b_o), 32'(sat));
      chk("sat_cnt_c", 100 + k, 32'(bus2.err_cnt_c_o), 32'(sat));
    end

    // Asynchronous reset with A FAULTY.
    apply(mk(0, 3'b000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0), 200);
    apply(mk(1, 3'b001, 0, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0), 201);
    apply(mk(1, 3'b001, 0, 2, 0, 0, 3'b001, 3'b000, 0, 0, 0), 202);
    apply(mk(1, 3'b001, 0, 3, 0, 0, 3'b001, 3'b000, 0, 0, 0), 203);
    apply(mk(1, 3'b001, 0, 4, 0, 0, 3'b000, 3'b001, 0, 1, 1), 204);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.err_a_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst", 205);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 3'b001, 0, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0), 206);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
